// File: rtl/fifo_core_if.sv
// fifo_core_if: write/read strobes, write data, read data and status flags of fifo_core.
// master drives i_wren/i_wrdata/i_rden and samples o_*; slave (the FIFO) does the reverse.
// No clock or reset inside; those stay plain ports on the modules.
interface fifo_core_if #(
    parameter int DATA_W = 8
);
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic [DATA_W-1:0] o_rddata;
    logic              o_full;
    logic              o_alm_full;
    logic              o_empty;
    logic              o_alm_empty;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_wren, i_wrdata, i_rden,
        input  o_rddata, o_full, o_alm_full, o_empty, o_alm_empty,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden,
        output o_rddata, o_full, o_alm_full, o_empty, o_alm_empty,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_core.sv
// fifo_core: synchronous single-clock FIFO, DEPTH x DATA_W, with full/almost-full/empty/almost-empty flags.
// Latency: read data registered, valid after the edge that accepts the read; a written word is readable one edge later.
// Backpressure: writes while full and reads while empty are dropped and flagged by one-cycle o_overflow/o_underflow pulses.
//
// Ports: clk (rising edge), rst (synchronous, active-high), bus (fifo_core_if.slave):
//   i_wren/i_wrdata write request + data, i_rden read request, o_rddata registered read data,
//   o_full/o_alm_full/o_empty/o_alm_empty occupancy flags, o_overflow/o_underflow error pulses.
// DEPTH must be a power of two >= 4 so the pointers wrap for free;
// 1 <= ALM_EMPTY_TH < ALM_FULL_TH <= DEPTH-1.
module fifo_core #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ALM_FULL_TH  = 14,
    parameter int ALM_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_core_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ALM_FUL = CW'(ALM_FULL_TH);
    localparam logic [CW-1:0] CNT_ALM_EMP = CW'(ALM_EMPTY_TH);

    // Storage is deliberately not reset; the pointers and count define validity.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;

    logic [DATA_W-1:0] rddata_q;
    logic              full_q;
    logic              alm_full_q;
    logic              empty_q;
    logic              alm_empty_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses the registered flags, i.e. the occupancy before this edge.
    // At full a simultaneous read still goes through; at empty a simultaneous write does.
    assign wr_acc = bus.i_wren & ~full_q;
    assign rd_acc = bus.i_rden & ~empty_q;

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Memory write port, kept apart from the reset block so the array stays plain RAM.
    // Gating with rst keeps a write that coincides with reset from landing.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= bus.i_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rddata_q    <= '0;
            full_q      <= 1'b0;
            alm_full_q  <= 1'b0;
            empty_q     <= 1'b1;
            alm_empty_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A write into an empty FIFO is not bypassed: rd_acc is false then,
            // so o_rddata holds until the word is read on a later edge.
            if (rd_acc) begin
                rddata_q <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            count <= count_nxt;

            // Flags come from next-state count so they line up with the new occupancy.
            full_q      <= (count_nxt == CNT_FULL);
            alm_full_q  <= (count_nxt >= CNT_ALM_FUL);
            empty_q     <= (count_nxt == '0);
            alm_empty_q <= (count_nxt <= CNT_ALM_EMP);

            // Error pulses re-evaluate every edge, so they last exactly one cycle
            // per offending request.
            overflow_q  <= bus.i_wren & full_q;
            underflow_q <= bus.i_rden & empty_q;
        end
    end

    assign bus.o_rddata    = rddata_q;
    assign bus.o_full      = full_q;
    assign bus.o_alm_full  = alm_full_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_alm_empty = alm_empty_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_fifo_core.sv
// tb_fifo_core: directed boundary scenarios plus a random phase for fifo_core.
// A queue-based reference model produces the expected post-edge outputs for every cycle;
// a monitor process compares them against the DUT one time-step after each rising edge.
module tb_fifo_core;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF_TH  = 14;
    localparam int AE_TH  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] rddata;
        logic [3:0]        flags;   // {full, alm_full, empty, alm_empty}
        logic              ovf;
        logic              udf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_core_if #(.DATA_W(DATA_W)) bus ();

    fifo_core #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ALM_FULL_TH (AF_TH),
        .ALM_EMPTY_TH(AE_TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: stored words in order, plus the last word read out.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] model_last;
    exp_t              exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // One clock of stimulus: drive at the falling edge, then predict the
    // outputs that must be visible after the following rising edge.
    task automatic cyc(input logic r, input logic wr, input logic [DATA_W-1:0] wd, input logic rd);
        exp_t e;
        int   occ;
        logic was_full, was_empty;
        @(negedge clk);
        rst          = r;
        bus.i_wren   = wr;
        bus.i_wrdata = wd;
        bus.i_rden   = rd;
        occ       = model_q.size();
        was_full  = (occ == DEPTH);
        was_empty = (occ == 0);
        if (r) begin
            model_q.delete();
            model_last = '0;
            e.ovf = 1'b0;
            e.udf = 1'b0;
        end else begin
            e.ovf = wr && was_full;
            e.udf = rd && was_empty;
            if (rd && !was_empty) model_last = model_q.pop_front();
            if (wr && !was_full)  model_q.push_back(wd);
        end
        occ      = model_q.size();
        e.rddata = model_last;
        e.flags  = {occ == DEPTH, occ >= AF_TH, occ == 0, occ <= AE_TH};
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per rising edge, checked 1 time-unit later.
    initial begin
        exp_t e;
        logic [3:0] got_flags;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cyc++;
                got_flags = {bus.o_full, bus.o_alm_full, bus.o_empty, bus.o_alm_empty};
                n_tests++;
                if (bus.o_rddata !== e.rddata) begin
                    n_fail++;
                    $display("FAIL rddata cyc=%0d got=%h exp=%h", n_cyc, bus.o_rddata, e.rddata);
                end
                n_tests++;
                if (got_flags !== e.flags) begin
                    n_fail++;
                    $display("FAIL flags{full,afull,empty,aempty} cyc=%0d got=%b exp=%b", n_cyc, got_flags, e.flags);
                end
                n_tests++;
                if ({bus.o_overflow, bus.o_underflow} !== {e.ovf, e.udf}) begin
                    n_fail++;
                    $display("FAIL err{ovf,udf} cyc=%0d got=%b exp=%b", n_cyc,
                             {bus.o_overflow, bus.o_underflow}, {e.ovf, e.udf});
                end
            end
        end
    end

    initial begin
        int budget;
        bus.i_wren   = 1'b0;
        bus.i_wrdata = '0;
        bus.i_rden   = 1'b0;
        model_last   = '0;

        // Reset then idle.
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        // Fill 0x00..0x0F, then one overflowing write.
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(i), 0);
        cyc(0, 1, 8'hAA, 0);
        cyc(0, 0, 8'h00, 0);

        // Drain, then one underflowing read (o_rddata must hold 0x0F).
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        // Simultaneous read/write at full, then at empty.
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(8'h20 + i), 0);
        cyc(0, 1, 8'h55, 1);
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 8'h00, 1);
        cyc(0, 1, 8'h77, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        // Wrap-around streaming at constant occupancy 4.
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h80 + i), 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 8'(8'h84 + i), 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);

        // Reset mid-operation with a concurrent write.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'hC0 + i), 0);
        cyc(1, 1, 8'hEE, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h3C, 0);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);

        // Random phases alternating write-heavy and read-heavy, with rare resets.
        for (int p = 0; p < 8; p++) begin
            int pw;
            int pr;
            pw = (p % 2 == 0) ? 80 : 30;
            pr = (p % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 60; i++) begin
                cyc($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < pw,
                    8'($urandom()),
                    $urandom_range(0, 99) < pr);
            end
        end

        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
